// File: rtl/pmem_loader_if.sv
// Byte-stream handshake into the program-memory loader.
// The producer drives valid/data and the loader answers with ready.
interface pmem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pmem_loader.sv
// Writable program memory filled from a byte stream (high byte, low byte per word),
// with a combinational fetch port for the CPU and a hold line while loading.
module pmem_loader #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 10,
  parameter int DEPTH   = 2**ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  pmem_loader_if.slave       s_in,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic [INSTR_W-1:0] cpu_instr,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    word_count
);

  localparam int HI_W = INSTR_W - 8;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    DONE,
    ERR
  } state_t;

  state_t              state_q, state_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [7:0]          lo_q, lo_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [INSTR_W-1:0]  mem_q [DEPTH];
  logic [INSTR_W-1:0]  mem_d [DEPTH];
  logic                in_ready;
  logic                xfer;

  // Status lines are pure decodes of the registered state.
  assign in_ready    = (state_q == HI) || (state_q == LO);
  assign s_in.in_ready = in_ready;
  assign xfer        = s_in.in_valid && in_ready;
  assign cpu_hold    = (state_q == HI) || (state_q == LO) ||
                       (state_q == WR) || (state_q == ERR);
  assign load_done   = (state_q == DONE);
  assign load_err    = (state_q == ERR);
  assign word_count  = word_count_q;
  assign cpu_instr   = mem_q[cpu_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      word_count_q <= '0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      word_count_q <= word_count_d;
      mem_q        <= mem_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    word_count_d = word_count_q;
    mem_d        = mem_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = HI;
          word_count_d = '0;
        end
      end
      HI: begin
        if (xfer) begin
          // Any set bit above the instruction's top bits marks a corrupt stream.
          if (s_in.in_data[7:HI_W] == '0) begin
            hi_d    = s_in.in_data[HI_W-1:0];
            state_d = LO;
          end else begin
            state_d = ERR;
          end
        end
      end
      LO: begin
        if (xfer) begin
          lo_d    = s_in.in_data;
          state_d = WR;
        end
      end
      WR: begin
        mem_d[word_count_q[ADDR_W-1:0]] = {hi_q, lo_q};
        word_count_d = word_count_q + 1'b1;
        state_d      = (word_count_q == LAST_WORD) ? DONE : HI;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Randomised bench for pmem_loader: a memory-image model checked through the fetch
// port, plus a completion scoreboard fed by the stimulus and drained by a monitor.
module tb_pmem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cpu_addr;
  logic [9:0] cpu_instr;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;
  logic [4:0] word_count;

  pmem_loader_if bus ();

  pmem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_in       (bus),
    .cpu_addr   (cpu_addr),
    .cpu_instr  (cpu_instr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int wc;
  } evt_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_mem [16];
  int         prog [16];
  logic [7:0] stream_q [$];
  evt_t       exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic readAll(input string tag);
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a);
      #1;
      checkOutput($sformatf("%s mem[%0d]", tag, a), 32'(cpu_instr), model_mem[a]);
    end
  endtask

  // mode 0: the fixed k-pattern program; otherwise a random program.
  task automatic buildProgram(input int mode);
    stream_q.delete();
    for (int k = 0; k < 16; k++) begin
      if (mode == 0) prog[k] = ((k & 3) << 8) | ((k * 17) & 255);
      else           prog[k] = int'($urandom_range(0, 1023));
      stream_q.push_back(8'(prog[k] >> 8));
      stream_q.push_back(8'(prog[k] & 255));
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams stream_q; bytes offered while in_ready is low are junk and must be ignored.
  task automatic applyStimulus(input bit rand_valid, input bit chk_pattern, input bit rand_start);
    int ptr = 0;
    int cyc = 0;
    bit acc;
    while (ptr < stream_q.size() && cyc < 1000) begin
      if (chk_pattern)
        checkOutput($sformatf("in_ready cyc%0d", cyc), 32'(bus.in_ready), 32'(cyc % 3 != 2));
      if (!rand_valid || !bus.in_ready) bus.in_valid = 1'b1;
      else                              bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data = bus.in_ready ? stream_q[ptr] : 8'($urandom_range(0, 255));
      start = rand_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) ptr++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    if (ptr < stream_q.size()) checkOutput("stream timeout", ptr, stream_q.size());
  endtask

  task automatic waitDone(input bit is_err);
    int n = 0;
    while (((is_err ? load_err : load_done) !== 1'b1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) checkOutput("completion timeout", 0, 1);
  endtask

  // Completion monitor: every rise of load_done/load_err consumes one expected event.
  initial begin
    bit   pd;
    bit   pe;
    evt_t e;
    pd = 1'b0;
    pe = 1'b0;
    forever begin
      @(posedge clk); #2;
      if ((load_done === 1'b1 && !pd) || (load_err === 1'b1 && !pe)) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected completion", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("completion kind", 32'(load_err), 32'(e.is_err));
          checkOutput("completion word_count", 32'(word_count), e.wc);
        end
      end
      pd = (load_done === 1'b1);
      pe = (load_err === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    cpu_addr = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;

    $display("[TB] reset state");
    checkOutput("reset cpu_hold", 32'(cpu_hold), 0);
    checkOutput("reset load_done", 32'(load_done), 0);
    checkOutput("reset load_err", 32'(load_err), 0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 0);
    checkOutput("reset word_count", 32'(word_count), 0);
    readAll("reset");

    $display("[TB] full load, in_valid held high");
    buildProgram(0);
    exp_q.push_back('{is_err: 1'b0, wc: 16});
    pulseStart();
    checkOutput("HI cpu_hold", 32'(cpu_hold), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cycle47 load_done", 32'(load_done), 0);
    @(posedge clk); #1;
    checkOutput("cycle48 load_done", 32'(load_done), 1);
    checkOutput("done word_count", 32'(word_count), 16);
    checkOutput("done cpu_hold", 32'(cpu_hold), 0);
    checkOutput("done in_ready", 32'(bus.in_ready), 0);
    foreach (prog[k]) model_mem[k] = prog[k];
    readAll("load1");
    cpu_addr = 4'd5;  #1; checkOutput("addr5 word", 32'(cpu_instr), 32'h155);
    cpu_addr = 4'd15; #1; checkOutput("addr15 word", 32'(cpu_instr), 32'h3FF);

    $display("[TB] same load from fresh reset with random in_valid");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;
    readAll("rst2");
    exp_q.push_back('{is_err: 1'b0, wc: 16});
    pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(1'b0);
    foreach (prog[k]) model_mem[k] = prog[k];
    readAll("load2");

    $display("[TB] malformed high byte");
    stream_q.delete();
    stream_q.push_back(8'h02);
    stream_q.push_back(8'hAB);
    stream_q.push_back(8'h84);
    exp_q.push_back('{is_err: 1'b1, wc: 1});
    pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(1'b1);
    model_mem[0] = 32'h2AB;
    checkOutput("err load_err", 32'(load_err), 1);
    checkOutput("err cpu_hold", 32'(cpu_hold), 1);
    checkOutput("err in_ready", 32'(bus.in_ready), 0);
    checkOutput("err word_count", 32'(word_count), 1);
    readAll("err");
    bus.in_valid = 1'b1;
    bus.in_data = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("err sticky", 32'(load_err), 1);
    pulseStart();
    checkOutput("restart load_err", 32'(load_err), 0);
    checkOutput("restart word_count", 32'(word_count), 0);
    checkOutput("restart in_ready", 32'(bus.in_ready), 1);
    buildProgram(1);
    exp_q.push_back('{is_err: 1'b0, wc: 16});
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(1'b0);
    foreach (prog[k]) model_mem[k] = prog[k];
    readAll("after err");

    $display("[TB] reset mid-load after 7 words");
    buildProgram(1);
    stream_q = stream_q[0:13];
    pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("partial word_count", 32'(word_count), 7);
    checkOutput("partial cpu_hold", 32'(cpu_hold), 1);
    for (int k = 0; k < 7; k++) model_mem[k] = prog[k];
    readAll("partial");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;
    checkOutput("abort cpu_hold", 32'(cpu_hold), 0);
    checkOutput("abort word_count", 32'(word_count), 0);
    checkOutput("abort in_ready", 32'(bus.in_ready), 0);
    checkOutput("abort load_done", 32'(load_done), 0);
    readAll("abort");

    $display("[TB] start pulses during load, then reload from DONE");
    buildProgram(1);
    exp_q.push_back('{is_err: 1'b0, wc: 16});
    pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitDone(1'b0);
    foreach (prog[k]) model_mem[k] = prog[k];
    readAll("noisy start");
    buildProgram(1);
    exp_q.push_back('{is_err: 1'b0, wc: 16});
    pulseStart();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(1'b0);
    foreach (prog[k]) model_mem[k] = prog[k];
    readAll("reload");

    $display("[TB] start together with rst");
    start = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    checkOutput("rst wins cpu_hold", 32'(cpu_hold), 0);
    checkOutput("rst wins in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst wins load_done", 32'(load_done), 0);

    repeat (2) @(posedge clk);
    #3;
    checkOutput("pending completions", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_loader.md
Name: pmem_loader

Overview:
- Writable 16 x 10-bit program memory with a byte-stream loader; the write-side counterpart of the CPU's instruction-fetch read port.
- Accepts a full program as pairs of bytes over a valid/ready handshake, assembles 10-bit instructions, and writes them sequentially from address 0.
- Holds the CPU via cpu_hold while loading. The CPU fetch stage reads through the same combinational addr -> instr port it uses today.

Parameters:
- ADDR_W, 4, program memory address width
- INSTR_W, 10, instruction width
- DEPTH, 16, number of words (2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load of DEPTH words
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- cpu_addr  input  ADDR_W  CPU fetch address
- cpu_instr  output  INSTR_W  instruction at cpu_addr (combinational)
- cpu_hold  output  1  CPU must stall/reset while high
- load_done  output  1  full program loaded successfully
- load_err  output  1  malformed high byte received
- word_count  output  ADDR_W+1  words written in current/last load (0..16)

Behaviour:
- Reset (rst=1 at a clk edge):
  - State becomes IDLE.
  - All memory words cleared to 0.
  - in_ready=0, cpu_hold=0, load_done=0, load_err=0, word_count=0.
  - Reset mid-load aborts the load immediately; no partial-state retention.
- Handshake:
  - A byte transfers only on a clk edge where in_valid && in_ready.
  - in_data is ignored otherwise.
  - in_ready is a registered-state decode: high only in HI and LO.
- States:
  - IDLE: in_ready=0, cpu_hold=0. start -> HI; word_count<=0, load_done<=0, load_err<=0.
  - HI: in_ready=1, cpu_hold=1. On transfer:
    - if in_data[7:2]==0: latch in_data[1:0] as instr[9:8] -> LO.
    - else: load_err<=1 -> ERR.
  - LO: in_ready=1, cpu_hold=1. On transfer: latch in_data as instr[7:0] -> WR.
  - WR: in_ready=0, cpu_hold=1.
    - mem[word_count[ADDR_W-1:0]] <= {hi,lo}; word_count <= word_count+1.
    - If word_count was DEPTH-1 -> DONE, else -> HI.
  - DONE: load_done=1, cpu_hold=0, in_ready=0. start -> HI (clears load_done, word_count).
  - ERR: load_err=1, cpu_hold=1, in_ready=0.
    - Memory keeps the words written so far.
    - start -> HI (clears load_err, word_count=0). Only start or rst leaves ERR.
- start while in HI, LO or WR is ignored.
- Throughput: minimum 3 cycles per word (HI, LO, WR). A full load takes at least 48 cycles from the first HI cycle. in_valid gaps stall in HI/LO indefinitely.
- Address wrap: the write address is word_count[ADDR_W-1:0]. It never wraps within a load because DONE is entered after word 15. word_count reads 16 in DONE.
- Read port: cpu_instr = mem[cpu_addr], combinational, valid in all states.
  - A write in WR is visible at the same cpu_addr from the next cycle.
  - cpu_hold covers the reads during load.
- Simultaneous start and rst: rst wins.

Test Plan:
1. rst, then read all 16 addresses -> cpu_instr=10'h000 everywhere; cpu_hold=0, load_done=0, in_ready=0.
2. start, then stream with in_valid held high: bytes {hi=k[1:0], lo=k*17 mod 256} for k=0..15.
   - in_ready pattern 1,1,0 repeating; load_done rises 48 cycles after the first HI cycle; word_count=16; cpu_hold falls.
   - Read: addr 5 -> {2'b01,8'h55}=10'h155; addr 15 -> {2'b11,8'hFF}=10'h3FF.
3. Same load with in_valid toggled randomly 50% -> identical memory contents. No byte accepted while in_ready=0 (check in WR).
4. start; send word0 = 8'h02, 8'hAB; then high byte 8'h84.
   - mem[0]=10'h2AB; load_err=1, cpu_hold=1, in_ready=0.
   - start clears load_err; a clean load then completes.
5. Reset mid-load after 7 words -> next cycle: state IDLE, all words 0, cpu_hold=0, word_count=0.
6. start pulsed in HI/LO/WR during a load -> ignored; word_count keeps incrementing. start in DONE reloads and overwrites contents.
